// File: rtl/hamming_codeword_rx.sv
// hamming_codeword_rx: oversampled UART-style framer delivering 8-bit codewords on a valid/ready port
module hamming_codeword_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int CW_WIDTH   = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                serial_in,
  input  logic                sample_tick,
  output logic [CW_WIDTH-1:0] codeword,
  output logic                cw_valid,
  input  logic                cw_ready,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(CW_WIDTH + 1);
  localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TOP = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(CW_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state;
  logic sync_1, rx_s;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_idx;
  logic [CW_WIDTH-1:0] shift_reg;
  assign busy = state != IDLE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1    <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      codeword  <= '0;
      cw_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync_1    <= serial_in;
      rx_s      <= sync_1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (cw_valid && cw_ready) cw_valid <= 1'b0;
      if (sample_tick) begin
        unique case (state)
          IDLE: if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
          START: if (tick_cnt == MID) begin
            state    <= rx_s ? IDLE : DATA;
            tick_cnt <= '0;
            bit_idx  <= '0;
          end else tick_cnt <= tick_cnt + 1'b1;
          DATA: if (tick_cnt == TOP) begin
            shift_reg <= {shift_reg[CW_WIDTH-2:0], rx_s};
            tick_cnt  <= '0;
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == LAST) state <= STOP;
          end else tick_cnt <= tick_cnt + 1'b1;
          STOP: if (tick_cnt == TOP) begin
            tick_cnt <= '0;
            state    <= rx_s ? IDLE : BREAK;
            frame_err <= !rx_s;
            // a word arriving while the previous one is still held is dropped,
            // unless the held word is being taken on this very edge
            if (rx_s && (!cw_valid || cw_ready)) begin
              codeword <= shift_reg;
              cw_valid <= 1'b1;
            end
            overrun <= rx_s && cw_valid && !cw_ready;
          end else tick_cnt <= tick_cnt + 1'b1;
          BREAK: if (rx_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hamming_codeword_rx.sv
// tb_hamming_codeword_rx: directed checks of framing, false start, framing error, overrun and reset
module tb_hamming_codeword_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic sample_tick = 1'b0;
  logic cw_ready = 1'b0;
  logic [7:0] codeword;
  logic cw_valid, frame_err, overrun, busy;
  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  localparam int BIT_CLKS = 32;
  hamming_codeword_rx #(.OVERSAMPLE(16), .CW_WIDTH(8)) dut (
    .clock(clk), .reset(rst), .serial_in(serial_in), .sample_tick(sample_tick),
    .codeword(codeword), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    sample_tick = ~sample_tick;
  end
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    serial_in = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(1'b1);
  endtask
  task automatic consume;
    cw_ready = 1'b1;
    @(negedge clk);
    cw_ready = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_codeword", 32'(codeword), 32'h00);
    chk("reset_valid", 32'(cw_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_flags", 32'({frame_err, overrun}), 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
  endtask
  task automatic test_clean_frame;
    logic [7:0] d = 8'hB4;
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    serial_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("clean_valid_before_stop", 32'(cw_valid), 32'h0);
    repeat (22) @(negedge clk);
    chk("clean_valid", 32'(cw_valid), 32'h1);
    chk("clean_codeword", 32'(codeword), 32'hB4);
    repeat (20) @(negedge clk);
    chk("clean_held", 32'({cw_valid, codeword}), 32'h1B4);
    chk("clean_no_flags", 32'(fe_cnt + ov_cnt), 32'h0);
    consume();
    chk("clean_cleared", 32'(cw_valid), 32'h0);
    repeat (40) @(negedge clk);
  endtask
  task automatic test_glitch;
    int fe0 = fe_cnt;
    serial_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("glitch_busy_rises", 32'(busy), 32'h1);
    repeat (2) @(negedge clk);
    serial_in = 1'b1;
    repeat (32) @(negedge clk);
    chk("glitch_busy_falls", 32'(busy), 32'h0);
    chk("glitch_no_valid", 32'(cw_valid), 32'h0);
    chk("glitch_no_flags", 32'(fe_cnt - fe0), 32'h0);
    repeat (40) @(negedge clk);
  endtask
  task automatic test_frame_error;
    logic [7:0] d = 8'h5A;
    int fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("ferr_one_pulse", 32'(fe_cnt - fe0), 32'h1);
    chk("ferr_no_valid", 32'(cw_valid), 32'h0);
    chk("ferr_break_held", 32'(busy), 32'h1);
    send_bit(1'b1);
    chk("ferr_break_exit", 32'(busy), 32'h0);
    send_frame(8'h3C);
    chk("ferr_next_frame", 32'({cw_valid, codeword}), 32'h13C);
    chk("ferr_count_stable", 32'(fe_cnt - fe0), 32'h1);
    consume();
    repeat (40) @(negedge clk);
  endtask
  task automatic test_overrun;
    int ov0 = ov_cnt;
    send_frame(8'h0F);
    send_frame(8'hF0);
    chk("ovr_pulse_once", 32'(ov_cnt - ov0), 32'h1);
    chk("ovr_old_kept", 32'({cw_valid, codeword}), 32'h10F);
    consume();
    chk("ovr_cleared", 32'(cw_valid), 32'h0);
    repeat (40) @(negedge clk);
    chk("ovr_new_dropped", 32'(cw_valid), 32'h0);
  endtask
  task automatic test_back_to_back;
    int ov0 = ov_cnt;
    int waited = 0;
    fork
      begin
        send_frame(8'h0F);
        send_frame(8'hF0);
      end
      begin
        while (!cw_valid && waited < 400) begin
          @(negedge clk);
          waited++;
        end
        chk("b2b_first_arrives", 32'(cw_valid), 32'h1);
        chk("b2b_first_word", 32'(codeword), 32'h0F);
        repeat (319) @(negedge clk);
        cw_ready = 1'b1;
        @(negedge clk);
        cw_ready = 1'b0;
        chk("b2b_swap", 32'({cw_valid, codeword}), 32'h1F0);
      end
    join
    chk("b2b_no_overrun", 32'(ov_cnt - ov0), 32'h0);
    chk("b2b_still_valid", 32'({cw_valid, codeword}), 32'h1F0);
    consume();
    repeat (40) @(negedge clk);
  endtask
  task automatic test_reset_mid_frame;
    logic [7:0] d = 8'hAA;
    send_frame(8'h55);
    chk("rmid_pending", 32'({cw_valid, codeword}), 32'h155);
    send_bit(1'b0);
    for (int i = 7; i >= 4; i--) send_bit(d[i]);
    serial_in = d[3];
    repeat (16) @(negedge clk);
    chk("rmid_busy_before", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rmid_outputs_zero", 32'({codeword, cw_valid, frame_err, overrun, busy}), 32'h0);
    @(negedge clk);
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (64) @(negedge clk);
    chk("rmid_idle_after", 32'({cw_valid, busy}), 32'h0);
    send_frame(8'h81);
    chk("rmid_next_frame", 32'({cw_valid, codeword}), 32'h181);
    consume();
  endtask
  initial begin
    test_reset();
    test_clean_frame();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
